// File: rtl/config_frame_writer.sv
// config_frame_writer: consumes a word stream, hunts for the sync word, then
// decodes header/data word pairs and drives one configuration frame per pair
// onto the fabric latch array (data on FrameData, one-cycle registered
// FrameStrobe/ColSelect pulse, then a one-cycle hold before the next header).
//
// Optional feature macro: CFG_FRAME_COUNT_EN adds a saturating 16-bit
// frame_count output that counts strobe cycles.

module config_frame_writer #(
    parameter int FRAME_BITS         = 32,
    parameter int MAX_FRAMES_PER_COL = 20,
    parameter int NUM_COLUMNS        = 16
) (
    input  logic                          CLK,
    input  logic                          resetn,
    input  logic [FRAME_BITS-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [FRAME_BITS-1:0]         FrameData,
    output logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe,
    output logic [NUM_COLUMNS-1:0]        ColSelect,
    output logic                          busy,
    output logic                          err
`ifdef CFG_FRAME_COUNT_EN
    ,
    output logic [15:0]                   frame_count
`endif
);

    // Stream control words; the header layout needs at least 32 bits.
    localparam logic [FRAME_BITS-1:0] SYNC_WORD   = FRAME_BITS'(32'hFAB0_FAB1);
    localparam logic [FRAME_BITS-1:0] DESYNC_WORD = FRAME_BITS'(32'hFAB0_FAB0);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        STROBE,
        HOLD
    } state_t;

    state_t                        state_q, state_d;
    logic [FRAME_BITS-1:0]         frame_data_q, frame_data_d;
    logic [MAX_FRAMES_PER_COL-1:0] strobe_q, strobe_d;
    logic [NUM_COLUMNS-1:0]        col_sel_q, col_sel_d;
    logic                          err_q, err_d;
    logic [7:0]                    column_q, column_d;
    logic [4:0]                    frame_q, frame_d;
    // Set when the latched header addresses a non-existent frame or column;
    // the paired data word is then swallowed without a strobe.
    logic                          bad_q, bad_d;

    logic       accept;
    logic [7:0] hdr_column;
    logic [4:0] hdr_frame;
    logic       hdr_bad;

    // Handshake and header field decode from the current word.
    assign s_ready    = (state_q == IDLE) || (state_q == HEADER) || (state_q == DATA);
    assign accept     = s_valid && s_ready;
    assign hdr_column = s_data[31:24];
    assign hdr_frame  = s_data[4:0];
    assign hdr_bad    = (32'(hdr_column) >= 32'(NUM_COLUMNS)) ||
                        (32'(hdr_frame)  >= 32'(MAX_FRAMES_PER_COL));

    // Next-state, datapath and registered-output decode for the frame FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned, which would infer a latch.
        state_d      = state_q;
        frame_data_d = frame_data_q;
        strobe_d     = '0;
        col_sel_d    = '0;
        err_d        = err_q;
        column_d     = column_q;
        frame_d      = frame_q;
        bad_d        = bad_q;

        unique case (state_q)
            IDLE: begin
                // Sync hunt: everything except the sync word is dropped.
                if (accept && (s_data == SYNC_WORD)) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (accept) begin
                    if (s_data == DESYNC_WORD) begin
                        state_d = IDLE;
                    end else begin
                        column_d = hdr_column;
                        frame_d  = hdr_frame;
                        bad_d    = hdr_bad;
                        err_d    = err_q | hdr_bad;
                        state_d  = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    if (bad_q) begin
                        state_d = HEADER;
                    end else begin
                        // Strobe is computed here so it appears registered,
                        // aligned with the STROBE state, and glitch-free.
                        frame_data_d = s_data;
                        strobe_d     = MAX_FRAMES_PER_COL'(1) << frame_q;
                        col_sel_d    = NUM_COLUMNS'(1) << column_q;
                        state_d      = STROBE;
                    end
                end
            end
            STROBE: begin
                state_d = HOLD;
            end
            HOLD: begin
                state_d = HEADER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, data and strobe registers with asynchronous clear.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            frame_data_q <= '0;
            strobe_q     <= '0;
            col_sel_q    <= '0;
            err_q        <= 1'b0;
            column_q     <= '0;
            frame_q      <= '0;
            bad_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            frame_data_q <= frame_data_d;
            strobe_q     <= strobe_d;
            col_sel_q    <= col_sel_d;
            err_q        <= err_d;
            column_q     <= column_d;
            frame_q      <= frame_d;
            bad_q        <= bad_d;
        end
    end

    assign FrameData   = frame_data_q;
    assign FrameStrobe = strobe_q;
    assign ColSelect   = col_sel_q;
    assign busy        = (state_q != IDLE);
    assign err         = err_q;

`ifdef CFG_FRAME_COUNT_EN
    logic [15:0] count_q, count_d;

    // Saturating count of strobe cycles; only reset clears it.
    always_comb begin
        count_d = count_q;
        if ((state_q == STROBE) && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Frame counter register.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign frame_count = count_q;
`endif

endmodule

// File: tb/tb_config_frame_writer.sv
// Self-checking bench for config_frame_writer: expected strobe events are
// queued as frames are driven and compared when the DUT strobes.

module tb_config_frame_writer;

    localparam int FB = 32;
    localparam int MF = 20;
    localparam int NC = 16;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic [FB-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [FB-1:0] FrameData;
    logic [MF-1:0] FrameStrobe;
    logic [NC-1:0] ColSelect;
    logic          busy;
    logic          err;
`ifdef CFG_FRAME_COUNT_EN
    logic [15:0]   frame_count;
`endif

    config_frame_writer #(
        .FRAME_BITS(FB),
        .MAX_FRAMES_PER_COL(MF),
        .NUM_COLUMNS(NC)
    ) dut (
        .CLK(CLK),
        .resetn(resetn),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .FrameData(FrameData),
        .FrameStrobe(FrameStrobe),
        .ColSelect(ColSelect),
        .busy(busy),
        .err(err)
`ifdef CFG_FRAME_COUNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [FB-1:0] data;
        logic [MF-1:0] strobe;
        logic [NC-1:0] col;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            strobe_cyc[$];
    logic          prev_strobe = 1'b0;
    logic [FB-1:0] last_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Monitor: pops the scoreboard on each strobe and checks the hold cycle.
    always @(negedge CLK) begin
        if (resetn) begin
            if (prev_strobe) begin
                check("hold_data", FrameData, last_data);
                check("hold_ready", s_ready, 1'b0);
                check("hold_strobe", FrameStrobe, '0);
            end
            if (FrameStrobe != '0) begin
                strobe_cyc.push_back(cyc);
                check("strobe_ready", s_ready, 1'b0);
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", FrameStrobe, '0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_data", FrameData, mon_e.data);
                    check("sb_strobe", FrameStrobe, mon_e.strobe);
                    check("sb_colsel", ColSelect, mon_e.col);
                end
                last_data   = FrameData;
                prev_strobe = 1'b1;
            end else begin
                check("colsel_quiet", ColSelect, '0);
                prev_strobe = 1'b0;
            end
        end else begin
            prev_strobe = 1'b0;
        end
    end

    // Offer one word and wait (bounded) until it is accepted.
    task automatic send(input logic [FB-1:0] w);
        logic acc;
        int   n;
        n       = 0;
        s_data  = w;
        s_valid = 1'b1;
        do begin
            acc = s_ready;
            @(posedge CLK);
            #1;
            n++;
        end while (!acc && n < 20);
        if (!acc) check("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Push the expected strobe event for a legal header, then send the pair.
    task automatic good_frame(input int col, input int fr, input logic [FB-1:0] d);
        exp_t e;
        logic [FB-1:0] hdr;
        e.data   = d;
        e.strobe = MF'(1) << fr;
        e.col    = NC'(1) << col;
        hdr      = (FB'(col) << 24) | FB'(fr);
        sb_q.push_back(e);
        send(hdr);
        send(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #2;
        check("rst_strobe", FrameStrobe, '0);
        check("rst_colsel", ColSelect, '0);
        check("rst_data", FrameData, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
`ifdef CFG_FRAME_COUNT_EN
        check("rst_count", frame_count, 16'd0);
`endif
        repeat (2) @(posedge CLK);
        #2 resetn = 1'b1;
        @(posedge CLK);
        #1;
        check("rel_ready", s_ready, 1'b1);

        // Basic frame: column 3, frame 5.
        send(32'hFAB0_FAB1);
        check("sync_busy", busy, 1'b1);
        good_frame(3, 5, 32'hDEAD_BEEF);
        s_valid = 1'b0;
        check("t1_data", FrameData, 32'hDEAD_BEEF);
        check("t1_strobe", FrameStrobe, MF'(1) << 5);
        check("t1_colsel", ColSelect, NC'(1) << 3);
        check("t1_ready0", s_ready, 1'b0);
        idle(1);
        check("t1_hold_strobe", FrameStrobe, '0);
        check("t1_ready1", s_ready, 1'b0);
        idle(1);
        check("t1_ready_back", s_ready, 1'b1);
        check("t1_busy", busy, 1'b1);

        // Garbage while in IDLE is discarded.
        send(32'hFAB0_FAB0);
        check("t2_idle", busy, 1'b0);
        send(32'h1234_5678);
        send(32'h0000_0000);
        idle(3);
        check("t2_busy", busy, 1'b0);
        check("t2_err", err, 1'b0);

        // Out-of-range frame, then out-of-range column, then a good frame.
        send(32'hFAB0_FAB1);
        send(32'h0000_0015);
        check("t3_err_set", err, 1'b1);
        send(32'h1111_1111);
        check("t3_back_header", s_ready, 1'b1);
        check("t3_no_strobe", FrameStrobe, '0);
        send(32'h1000_0001);
        send(32'h2222_2222);
        check("t3_col_no_strobe", FrameStrobe, '0);
        good_frame(1, 2, 32'hCAFE_F00D);
        idle(3);
        check("t3_err_sticky", err, 1'b1);

        // Back-to-back frames at the address boundaries, s_valid held high.
        strobe_cyc.delete();
        good_frame(NC - 1, MF - 1, 32'hA5A5_A5A5);
        good_frame(0, 0, 32'h5A5A_5A5A);
        idle(4);
        check("t4_strobes", strobe_cyc.size(), 2);
        if (strobe_cyc.size() == 2) check("t4_spacing", strobe_cyc[1] - strobe_cyc[0], 4);

        // Desync returns to IDLE; a header-format word is then ignored.
        send(32'hFAB0_FAB0);
        check("t5_busy", busy, 1'b0);
        send(32'h0300_0005);
        send(32'h7777_7777);
        idle(3);
        check("t5_still_idle", busy, 1'b0);

        // Reset in the middle of a strobe.
        send(32'hFAB0_FAB1);
        send(32'h0200_0003);
        send(32'h9999_9999);
        s_valid = 1'b0;
        check("t6_strobing", FrameStrobe, MF'(1) << 3);
`ifdef CFG_FRAME_COUNT_EN
        check("t6_count", frame_count, 16'd4);
`endif
        resetn = 1'b0;
        #1;
        check("t6_strobe_drop", FrameStrobe, '0);
        check("t6_colsel_drop", ColSelect, '0);
        check("t6_data_clr", FrameData, '0);
        check("t6_busy", busy, 1'b0);
        check("t6_err_clr", err, 1'b0);
`ifdef CFG_FRAME_COUNT_EN
        check("t6_count_clr", frame_count, 16'd0);
`endif
        @(posedge CLK);
        #2 resetn = 1'b1;
        @(posedge CLK);
        #1;
        check("t6_ready", s_ready, 1'b1);
        send(32'h0300_0005);
        send(32'h8888_8888);
        idle(3);
        check("t6_unsynced", busy, 1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/config_frame_writer.md
CONFIG_FRAME_WRITER -- requirements
Module: config_frame_writer

Interface
REQ-001: Parameter FRAME_BITS, default 32; configuration latches per frame row, equal to the word width.
REQ-002: Parameter MAX_FRAMES_PER_COL, default 20; frames per fabric column, which sets the FrameStrobe width.
REQ-003: Parameter NUM_COLUMNS, default 16; fabric columns, which sets the ColSelect width.
REQ-004: Clock and reset SHALL be one clock, CLK, and reset resetn, which is asynchronous and active-low.
REQ-005: Port CLK  input  1  rising-edge clock.
REQ-006: Port resetn  input  1  asynchronous active-low reset.
REQ-007: Port s_data  input  FRAME_BITS  bitstream word.
REQ-008: Port s_valid  input  1  s_data valid.
REQ-009: Port s_ready  output  1  block accepts the word this cycle.
REQ-010: Port FrameData  output  FRAME_BITS  data driven onto the latch D pins.
REQ-011: Port FrameStrobe  output  MAX_FRAMES_PER_COL  one-hot latch enable (E) for the addressed frame.
REQ-012: Port ColSelect  output  NUM_COLUMNS  one-hot column qualifier, valid while FrameStrobe is non-zero.
REQ-013: Port busy  output  1  high whenever the state is not IDLE.
REQ-014: Port err  output  1  sticky error flag.

Function
REQ-015: A word transfers on a rising CLK edge only when s_valid=1 and s_ready=1.
REQ-016: FSM states SHALL be IDLE, HEADER, DATA, STROBE and HOLD; s_ready=1 in IDLE, HEADER and DATA, and s_ready=0 in STROBE and HOLD.
REQ-017: In IDLE, the block discards every accepted word except the sync word 32'hFAB0_FAB1, which moves the FSM to HEADER.
REQ-018: In HEADER, accepting 32'hFAB0_FAB0 (desync) moves the FSM to IDLE.
REQ-019: In HEADER, any other accepted word latches column = word[31:24] and frame = word[4:0], then moves to DATA.
REQ-020: If column >= NUM_COLUMNS or frame >= MAX_FRAMES_PER_COL, the block SHALL set err, accept and discard the next DATA word, issue no strobe, and return to HEADER.
REQ-021: In DATA, an accepted word loads FrameData and moves the FSM to STROBE.
REQ-022: STROBE lasts exactly one cycle, with FrameStrobe[frame]=1 and ColSelect[column]=1 and all other bits 0.
REQ-023: HOLD lasts exactly one cycle with FrameStrobe=0, then the FSM returns to HEADER.
REQ-024: FrameData SHALL stay stable from the DATA acceptance edge until the next DATA acceptance; it is never changed during STROBE or HOLD.
REQ-025: Minimum frame cost is 4 cycles (header, data, strobe, hold); back-to-back frames need no sync word between them.
REQ-026: FrameStrobe and ColSelect SHALL be registered outputs; they are glitch-free and are never asserted outside STROBE.
REQ-027: s_valid=0 in HEADER or DATA holds the current state indefinitely, with no timeout.
REQ-028: err clears only on reset.

Reset
REQ-029: On resetn=0, asynchronously: state=IDLE, FrameData=0, FrameStrobe=0, ColSelect=0, busy=0, err=0, and s_ready=1 after release.
REQ-030: A reset during STROBE SHALL drop FrameStrobe within the same reset assertion, with no partial-cycle strobe after release.
REQ-031: The first accepted word after release is evaluated as a sync hunt in IDLE.

Configuration
REQ-032: Macro CFG_FRAME_COUNT_EN, when defined, adds output frame_count (16 bits, reset 0).
REQ-033: frame_count increments once per STROBE cycle, saturates at 16'hFFFF, and is not cleared by desync.
REQ-034: Without CFG_FRAME_COUNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035: Reset, then words FAB0_FAB1, 0x0300_0005, 0xDEAD_BEEF -> FrameData=DEADBEEF; after one cycle, FrameStrobe=1<<5 and ColSelect=1<<3 for exactly one cycle; s_ready=0 for 2 cycles.
REQ-036: Words 0x1234_5678 then 0x0000_0000 while in IDLE -> no strobe, busy stays 0, err stays 0.
REQ-037: After sync, header 0x0000_0015 (frame 21) plus data -> err=1 and no strobe; a following valid header and data -> strobe issued and err still 1.
REQ-038: Two back-to-back frames with s_valid held high -> strobes exactly 4 cycles apart, with FrameData unchanged during each STROBE/HOLD window.
REQ-039: Assert resetn=0 during STROBE -> FrameStrobe=0 immediately; with CFG_FRAME_COUNT_EN, frame_count=0; after release, an unsynced header is ignored.
REQ-040: Desync 0xFAB0_FAB0 in HEADER -> busy=0 on the next cycle; a following header-format word produces no strobe.
